// File: rtl/led_pkg.sv
// led_pkg: shared constants for the LED pattern engine.
//   - pattern mode encodings (the value driven on Mode)
//   - push-button count and the role of each button index
//   - bounce direction encoding
//   - seed helper: which modes start from a single lit LED
package led_pkg;

    localparam logic [1:0] MODE_ROTATE = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_COUNT  = 2'd2;
    localparam logic [1:0] MODE_FILL   = 2'd3;

    localparam int NUM_BTN    = 4;
    localparam int BTN_MODE   = 0;
    localparam int BTN_SPEED  = 1;
    localparam int BTN_BRIGHT = 2;
    localparam int BTN_DIR    = 3;

    localparam logic BDIR_UP   = 1'b0;
    localparam logic BDIR_DOWN = 1'b1;

    // ROTATE and BOUNCE start from a single lit LED; COUNT and FILL start dark.
    function automatic logic seed_is_one(input logic [1:0] m);
        return (m == MODE_ROTATE) || (m == MODE_BOUNCE);
    endfunction

endpackage

// File: rtl/led_debounce.sv
// led_debounce: debouncer for one raw active-low push button.
//   Clk    in  system clock
//   Reset  in  synchronous active-high reset (button taken as released)
//   btn_n  in  raw button level, 0 = pressed, asynchronous to Clk
//   press  out one-cycle pulse when a pressed level is accepted
// The raw level passes a 2-flop synchroniser. A counter runs while the
// synchronised level differs from the accepted level and clears whenever they
// agree; once it has saturated and the difference is still there, the accepted
// level flips. Only the released->pressed flip emits a pulse.
module led_debounce #(
    parameter int DEB_W = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_n,
    output logic press
);

    logic             sync1;
    logic             sync2;
    logic             state;
    logic [DEB_W-1:0] cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            state <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == state) begin
                cnt <= '0;
            end else if (&cnt) begin
                state <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else begin
                cnt <= cnt + DEB_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: LED bank pattern generator driven by four push buttons.
//   Clk     in  board clock, single clock domain
//   Reset   in  synchronous active-high reset
//   Switch  in  4 raw active-low buttons: [0] mode, [1] speed, [2] brightness,
//               [3] direction (toggles bounce direction while in BOUNCE)
//   LED     out registered LED drive, 1 = lit
//   Mode    out current pattern mode
// A free-running prescaler produces a one-cycle step strobe every
// 2^(TICK_W-speed) cycles; the pattern register advances on that strobe.
// A free-running PWM counter gates the pattern for brightness control.
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int LED_W  = 8,
    parameter int TICK_W = 25,
    parameter int DEB_W  = 16,
    parameter int PWM_W  = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NUM_BTN-1:0] Switch,
    output logic [LED_W-1:0]   LED,
    output logic [1:0]         Mode
);

    logic [NUM_BTN-1:0] press;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
        led_debounce #(.DEB_W(DEB_W)) u_deb (
            .Clk   (Clk),
            .Reset (Reset),
            .btn_n (Switch[i]),
            .press (press[i])
        );
    end

    logic [TICK_W-1:0] cnt;
    logic              step_en;
    logic [PWM_W-1:0]  pc;
    logic [PWM_W-1:0]  duty;
    logic [1:0]        speed;
    logic              dir;
    logic              bdir;
    logic [LED_W-1:0]  p;

    logic [TICK_W-1:0] tick_mask;
    logic              lit;
    logic [1:0]        mode_nxt;
    logic [LED_W-1:0]  seed;
    logic [LED_W-1:0]  p_step;
    logic              bdir_step;
    logic              bdir_nxt;

    // Masking the top 'speed' bits out of the all-ones test shortens the
    // step period by 2^speed without touching the free-running counter.
    assign tick_mask = {TICK_W{1'b1}} >> speed;
    assign lit       = (pc <= duty);
    assign mode_nxt  = Mode + 2'd1;
    assign seed      = seed_is_one(mode_nxt) ? LED_W'(1) : '0;

    always_comb begin
        p_step    = p;
        bdir_step = bdir;
        case (Mode)
            MODE_ROTATE: p_step = dir ? {p[LED_W-2:0], p[LED_W-1]}
                                      : {p[0], p[LED_W-1:1]};
            MODE_BOUNCE: begin
                if (bdir == BDIR_UP) begin
                    if (p[LED_W-1]) begin
                        bdir_step = BDIR_DOWN;
                        p_step    = p >> 1;
                    end else begin
                        p_step = p << 1;
                    end
                end else begin
                    if (p[0]) begin
                        bdir_step = BDIR_UP;
                        p_step    = p << 1;
                    end else begin
                        p_step = p >> 1;
                    end
                end
            end
            MODE_COUNT: p_step = dir ? p - LED_W'(1) : p + LED_W'(1);
            MODE_FILL: begin
                if (&p)       p_step = '0;
                else if (dir) p_step = {1'b1, p[LED_W-1:1]};
                else          p_step = {p[LED_W-2:0], 1'b1};
            end
            default: p_step = p;
        endcase
    end

    // Bounce direction: a step may reverse it, and a direction press in
    // BOUNCE mode toggles whatever the step left behind.
    always_comb begin
        bdir_nxt = step_en ? bdir_step : bdir;
        if (press[BTN_DIR] && (Mode == MODE_BOUNCE))
            bdir_nxt = ~bdir_nxt;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt     <= '0;
            step_en <= 1'b0;
            pc      <= '0;
            duty    <= '1;
            speed   <= 2'd0;
            dir     <= 1'b0;
            bdir    <= BDIR_UP;
            p       <= LED_W'(1);
            Mode    <= MODE_ROTATE;
            LED     <= '0;
        end else begin
            cnt     <= cnt + TICK_W'(1);
            step_en <= &(cnt | ~tick_mask);
            pc      <= pc + PWM_W'(1);
            LED     <= p & {LED_W{lit}};

            if (press[BTN_SPEED])  speed <= speed + 2'd1;
            if (press[BTN_BRIGHT]) duty  <= duty + PWM_W'(1);
            if (press[BTN_DIR] && (Mode != MODE_BOUNCE)) dir <= ~dir;

            // A mode press reloads the seed and swallows a coincident step.
            if (press[BTN_MODE]) begin
                Mode <= mode_nxt;
                p    <= seed;
                bdir <= BDIR_UP;
            end else begin
                bdir <= bdir_nxt;
                if (step_en) p <= p_step;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
module tb_led_pattern_engine;

    localparam int LED_W  = 8;
    localparam int TICK_W = 6;
    localparam int DEB_W  = 2;
    localparam int PWM_W  = 2;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [3:0]       Switch;
    logic [LED_W-1:0] LED;
    logic [1:0]       Mode;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    led_pattern_engine #(
        .LED_W (LED_W),
        .TICK_W(TICK_W),
        .DEB_W (DEB_W),
        .PWM_W (PWM_W)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Switch(Switch),
        .LED   (LED),
        .Mode  (Mode)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance n rising edges, ending on the following falling edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            @(negedge Clk);
        end
    endtask

    // hold the masked buttons low for len edges, then release all
    task automatic push(input logic [3:0] mask, input int len);
        Switch = Switch & ~mask;
        cyc(len);
        Switch = 4'hF;
    endtask

    // wait for LED to change, bounded by limit edges
    task automatic wait_led(input int limit, output int cycles);
        logic [LED_W-1:0] prev;
        prev   = LED;
        cycles = 0;
        while ((LED === prev) && (cycles < limit)) begin
            cyc(1);
            cycles++;
        end
        if (LED === prev) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_led: no LED change within %0d cycles, LED=%0h", limit, LED);
        end
    endtask

    task automatic count_lit(input int win, output int lit_cnt);
        lit_cnt = 0;
        for (int k = 0; k < win; k++) begin
            cyc(1);
            if (LED != '0) lit_cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int lit_cnt;
        logic [7:0] bounce_seq [8];
        logic [7:0] fill_seq [10];
        bounce_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
        fill_seq   = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00, 8'h01};

        // reset, then rotate right at period 64
        Reset  = 1'b1;
        Switch = 4'hF;
        cyc(3);
        chk("reset_mode", Mode, 2'd0);
        Reset = 1'b0;
        cyc(1);
        chk("post_reset_led", LED, 8'h01);
        chk("post_reset_mode", Mode, 2'd0);
        wait_led(150, c);
        chk("rot_first_latency", c, 65);
        chk("rot_first", LED, 8'h80);
        wait_led(150, c);
        chk("rot_period", c, 64);
        chk("rot_second", LED, 8'h40);

        // 3-cycle glitch is rejected
        push(4'b0001, 3);
        cyc(8);
        chk("glitch_mode", Mode, 2'd0);

        // full press: Mode changes on edge 7 after the first low sample
        Switch[0] = 1'b0;
        cyc(6);
        chk("press_edge6_mode", Mode, 2'd0);
        cyc(1);
        chk("press_edge7_mode", Mode, 2'd1);
        cyc(1);
        Switch = 4'hF;
        chk("bounce_seed", LED, 8'h01);
        for (int i = 0; i < 8; i++) begin
            wait_led(150, c);
            chk($sformatf("bounce_%0d", i), LED, bounce_seq[i]);
        end

        // COUNT: up, then direction press turns it into a down-counter
        cyc(8);
        push(4'b0001, 8);
        chk("count_mode", Mode, 2'd2);
        chk("count_seed", LED, 8'h00);
        wait_led(150, c);
        chk("count_up", LED, 8'h01);
        cyc(8);
        push(4'b1000, 8);
        wait_led(150, c);
        chk("count_dn0", LED, 8'h00);
        wait_led(150, c);
        chk("count_dnFF", LED, 8'hFF);
        wait_led(150, c);
        chk("count_dnFE", LED, 8'hFE);

        // three speed presses: period 8
        cyc(8);
        for (int i = 0; i < 3; i++) begin
            push(4'b0010, 8);
            cyc(8);
        end
        wait_led(150, c);
        wait_led(150, c);
        chk("speed3_period", c, 8);
        chk("speed_mode_kept", Mode, 2'd2);

        // simultaneous mode + dir press: FILL with dir back to 0
        cyc(8);
        push(4'b1001, 8);
        chk("fill_mode", Mode, 2'd3);
        chk("fill_seed", LED, 8'h00);
        for (int i = 0; i < 10; i++) begin
            wait_led(150, c);
            chk($sformatf("fill_%0d", i), LED, fill_seq[i]);
        end

        // mode + brightness together: ROTATE, duty 0 -> 1 of 4 lit
        cyc(8);
        push(4'b0101, 8);
        chk("pwm_mode", Mode, 2'd0);
        cyc(2);
        count_lit(16, lit_cnt);
        chk("pwm_duty0", lit_cnt, 4);
        push(4'b0100, 8);
        cyc(2);
        count_lit(16, lit_cnt);
        chk("pwm_duty1", lit_cnt, 8);
        push(4'b0100, 8);
        cyc(8);
        push(4'b0100, 8);
        cyc(2);
        count_lit(16, lit_cnt);
        chk("pwm_duty3", lit_cnt, 16);

        // mode press lands on the same edge as a step: seed wins, step dropped
        cyc(8);
        wait_led(150, c);
        push(4'b0001, 8);
        chk("collide_mode", Mode, 2'd1);
        chk("collide_seed", LED, 8'h01);
        cyc(7);
        chk("collide_no_step", LED, 8'h01);
        cyc(1);
        chk("collide_next_step", LED, 8'h02);

        // reset in the middle of a debounce discards the partial count
        cyc(8);
        Switch[0] = 1'b0;
        cyc(4);
        Reset = 1'b1;
        cyc(2);
        chk("midrst_mode", Mode, 2'd0);
        Reset = 1'b0;
        cyc(1);
        chk("midrst_led", LED, 8'h01);
        chk("midrst_mode_rel", Mode, 2'd0);
        cyc(2);
        Switch = 4'hF;
        cyc(12);
        chk("midrst_no_press", Mode, 2'd0);
        chk("midrst_led_hold", LED, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_pattern_engine.md
# led_pattern_engine

Parametrised LED pattern generator for the board bring-up designs: drives an LED_W-wide LED bank from four debounced active-low push buttons. It adds four selectable patterns, four speed settings, direction control and PWM brightness on top of the basic single-pattern rotate. It sits directly between the board button pads and the LED pads, clocked from the 100 MHz board clock.

## Interface
- LED_W, 8: LED count, ≥2
- TICK_W, 25: prescaler width, ≥4; step period is 2^(TICK_W−speed) cycles
- DEB_W, 16: debounce counter width; a level must be stable 2^DEB_W cycles to be accepted
- PWM_W, 4: brightness resolution
- Clk  in  1  single clock for all logic
- Reset  in  1  synchronous, active-high
- Switch  in  4  raw push buttons, active-low (0 = pressed), asynchronous to Clk
- LED  out  LED_W  registered LED drive, 1 = lit
- Mode  out  2  current pattern mode, registered

## Operation
- Buttons: one press pulse per accepted press (pressed-level acceptance only; release emits nothing).
  - Switch[0]: Mode ← Mode+1, wrapping 3→0.
  - Switch[1]: speed ← speed+1, wrapping 3→0.
  - Switch[2]: duty ← duty+1 (PWM_W bits), wrapping max→0.
  - Switch[3]: dir ← ~dir.
- Modes (pattern register p, LED_W bits), advanced only on a step:
  - 0 ROTATE: seed 1. dir0 {p[0],p[W−1:1]}; dir1 {p[W−2:0],p[W−1]}.
  - 1 BOUNCE: seed 1, internal bdir = up. Up: if p[W−1] then bdir←down and p←p>>1, else p←p<<1. Down mirrors this at p[0]. Switch[3] in this mode toggles bdir instead of dir.
  - 2 COUNT: seed 0. dir0 p+1, dir1 p−1, modulo 2^LED_W.
  - 3 FILL: seed 0. If p all ones then p←0; else dir0 p←{p[W−2:0],1'b1}, dir1 p←{1'b1,p[W−1:1]}.
- Mode press reloads p with the new mode's seed and bdir ← up. It does not reset the prescaler.
- Step: free-running TICK_W prescaler cnt. step_en is registered as &cnt[TICK_W−1−speed:0], so it is high one cycle per period.
- PWM: free-running PWM_W counter pc. lit = (pc ≤ duty), so max duty is always on and duty 0 gives 1/2^PWM_W. LED ← p & {LED_W{lit}}.
- Reset values: cnt 0, step_en 0, pc 0, p 1, Mode 0, speed 0, dir 0, bdir up, duty all ones, debouncers released. LED reads 1 from the first edge after Reset deasserts.
- Reset held mid-operation discards all state, including partially counted debounces.

## Timing
- Debounce: 2-flop synchroniser, then counter. The counter increments while the synced level differs from the accepted state and clears when they are equal. When it reaches 2^DEB_W−1 with a difference still present, the state flips.
  - A press pulse goes high for exactly one cycle after edge 2^DEB_W+2, counting edge 1 as the first edge sampling the low level.
  - Glitches shorter than 2^DEB_W cycles produce no pulse.
- Control registers (Mode, speed, duty, dir/bdir, seed reload) update on the edge where the press pulse is high. LED reflects the change one edge later.
- Step: p updates on the edge where step_en is high; LED follows one edge later.
- Simultaneous mode press and step: the mode reload wins and the step is dropped.
- Simultaneous presses on different buttons are all applied in the same edge.
- Speed change takes effect at the next matching cnt pattern; no extra or lost step beyond the natural mask change.

## Structure
- Package led_pkg: mode encodings MODE_ROTATE=0, MODE_BOUNCE=1, MODE_COUNT=2, MODE_FILL=3; NUM_BTN=4; button index constants BTN_MODE/BTN_SPEED/BTN_BRIGHT/BTN_DIR.
- Sub-module led_debounce (param DEB_W; ports Clk, Reset, btn_n, press), instantiated 4×.
- Top holds the prescaler, PWM counter, control registers, pattern next-state logic and output register.

## Test plan
Bench parameters: LED_W=8, TICK_W=6, DEB_W=2, PWM_W=2.
- Reset, no buttons → LED=0x01 after release. With duty=3, LED rotates 0x01→0x80→0x40 every 64 cycles.
- Switch[0] low for 3 cycles → no press, Mode stays 0. Low for 8 cycles → Mode=1, LED=0x01, then bounces 0x02…0x80→0x40.
- Mode=2 (COUNT), Switch[3] press → LED counts 0x00→0xFF→0xFE. Switch[1] pressed 3× → step period 8 cycles.
- Mode=3 (FILL) → 0x01,0x03,…,0xFF,0x00 repeating.
- Switch[2] press with duty=3 → duty 0, LED lit 1 of every 4 cycles. Next press → lit 2 of 4.
- Force a step and a mode press on the same edge → seed loaded, no step. Assert Reset mid-debounce → no press after release, all outputs at reset values.
